// File: rtl/mac_sequencer_if.sv
// Stream bundle around the MAC sequencer: B-vector and matrix-element inputs, per-row results.
// The master modport is the sequencer's view. The slave modport is the surrounding FIFOs/sink.
interface mac_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      b_valid;
    logic                      b_ready;
    logic [DATA_WIDTH-1:0]     b_data;
    logic                      a_valid;
    logic                      a_ready;
    logic [DATA_WIDTH-1:0]     a_data;
    logic                      res_valid;
    logic                      res_ready;
    logic [3*DATA_WIDTH-1:0]   res_data;

    modport master (
        input  b_valid, b_data, a_valid, a_data, res_ready,
        output b_ready, a_ready, res_valid, res_data
    );

    modport slave (
        output b_valid, b_data, a_valid, a_data, res_ready,
        input  b_ready, a_ready, res_valid, res_data
    );
endinterface

// File: rtl/mac_sequencer.sv
// Loads a B vector, then streams each matrix row with the matching B element into one MAC,
// clearing it before the row, flushing its product register after it and publishing the sum.
module mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 8,
    parameter int NUM_ROWS   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    mac_sequencer_if.master         bus,
    output logic                    mac_clr,
    output logic                    mac_en,
    output logic [DATA_WIDTH-1:0]   mac_ain,
    output logic [DATA_WIDTH-1:0]   mac_bin,
    input  logic [3*DATA_WIDTH-1:0] mac_cout
);
    localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_B, CLEAR, STREAM, FLUSH, CAPTURE, OUTPUT, DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [ROW_W-1:0]        row;
    logic [DATA_WIDTH-1:0]   bbuf [VEC_LEN];
    logic                    res_valid_q;
    logic [3*DATA_WIDTH-1:0] res_data_q;
    logic                    b_ready_c, a_ready_c;
    logic                    b_xfer, a_xfer, res_xfer;

    assign b_xfer   = bus.b_valid && b_ready_c;
    assign a_xfer   = bus.a_valid && a_ready_c;
    assign res_xfer = res_valid_q && bus.res_ready;

    assign busy          = (state != IDLE);
    assign bus.b_ready   = b_ready_c;
    assign bus.a_ready   = a_ready_c;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

    always_comb begin
        state_nxt = state;
        b_ready_c = 1'b0;
        a_ready_c = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        mac_ain   = '0;
        mac_bin   = '0;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = LOAD_B;
            LOAD_B: begin
                b_ready_c = 1'b1;
                if (bus.b_valid && idx == IDX_LAST) state_nxt = CLEAR;
            end
            CLEAR: begin
                mac_clr   = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                // Operands are gated to zero on bubbles so the MAC never sees stale data.
                a_ready_c = 1'b1;
                mac_en    = bus.a_valid;
                if (bus.a_valid) begin
                    mac_ain = bus.a_data;
                    mac_bin = bbuf[idx];
                    if (idx == IDX_LAST) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Zero operands retire the last registered product and leave the product reg at 0.
                mac_en    = 1'b1;
                state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = OUTPUT;
            OUTPUT:  if (res_xfer) state_nxt = (row == ROW_LAST) ? DONE : CLEAR;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            row         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            for (int i = 0; i < VEC_LEN; i++) bbuf[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    idx <= '0;
                    row <= '0;
                end
                LOAD_B: if (b_xfer) begin
                    bbuf[idx] <= bus.b_data;
                    idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
                CLEAR:  idx <= '0;
                STREAM: if (a_xfer) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                CAPTURE: begin
                    res_valid_q <= 1'b1;
                    res_data_q  <= mac_cout;
                end
                OUTPUT: if (res_xfer) begin
                    res_valid_q <= 1'b0;
                    if (row != ROW_LAST) row <= row + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
